// File: rtl/ext_prog_bridge.sv
// ext_prog_bridge: routes CPU instruction fetches to internal program memory or to an
// external 4-phase bus, with a bounded wait that returns ERR_WORD and flags err on timeout.
module ext_prog_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] adress,
    input  logic        req,
    input  logic        cs,
    input  logic [31:0] int_data,
    output logic [31:0] ext_addr,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [31:0] ext_data,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, DECODE, INT_RD, EXT_REQ, EXT_REL, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          err_flag;
    logic          timeout;

    assign timeout = cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Ack is checked before timeout so a late ack on the last wait cycle still delivers data.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req ? DECODE : IDLE;
            DECODE:  state_nx = cs ? EXT_REQ : INT_RD;
            INT_RD:  state_nx = DONE;
            EXT_REQ: state_nx = (ext_ack || timeout) ? EXT_REL : EXT_REQ;
            EXT_REL: state_nx = ext_ack ? EXT_REL : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ext_req = state == EXT_REQ;
        ready   = state == DONE;
        err     = (state == DONE) && err_flag;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ext_addr <= '0;
            rdata    <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE && req) ext_addr <= adress;
            if (state == INT_RD) rdata <= int_data;
            if (state == EXT_REQ) begin
                if (ext_ack) rdata <= ext_data;
                else if (timeout) begin
                    rdata    <= ERR_WORD;
                    err_flag <= 1'b1;
                end else cnt <= cnt + 1'b1;
            end
            if (state == DONE) begin
                cnt      <= '0;
                err_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ext_prog_bridge.sv
// tb_ext_prog_bridge: directed fetch sequences against ext_prog_bridge with
// hand-computed expectations checked by immediate assertions.
module tb_ext_prog_bridge;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] adress = '0;
    logic        req = 1'b0;
    logic        cs = 1'b0;
    logic [31:0] int_data = '0;
    logic [31:0] ext_addr;
    logic        ext_req;
    logic        ext_ack = 1'b0;
    logic [31:0] ext_data = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int errors = 0;
    int checks = 0;

    ext_prog_bridge dut (
        .Clk(Clk), .Rst(Rst), .adress(adress), .req(req), .cs(cs), .int_data(int_data),
        .ext_addr(ext_addr), .ext_req(ext_req), .ext_ack(ext_ack), .ext_data(ext_data),
        .rdata(rdata), .ready(ready), .err(err)
    );

    always #5 Clk = ~Clk;

    logic saw_ext_req = 1'b0;

    task automatic tick();
        @(posedge Clk);
        #1;
        if (ext_req === 1'b1) saw_ext_req = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int idx1, idx2;
        logic [31:0] rd1, rd2;
        #3;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_ext_req", {31'd0, ext_req}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ext_addr", ext_addr, 32'd0);
        #10 Rst = 1'b1;
        tick();

        // internal fetch
        adress = 32'h1030; cs = 1'b0; int_data = 32'h2002_0005; req = 1'b1; saw_ext_req = 1'b0;
        tick();
        check("int_addr_latch", ext_addr, 32'h1030);
        check("int_ready_c1", {31'd0, ready}, 32'd0);
        tick();
        check("int_ready_c2", {31'd0, ready}, 32'd0);
        tick();
        check("int_ready_c3", {31'd0, ready}, 32'd1);
        check("int_rdata", rdata, 32'h2002_0005);
        check("int_err", {31'd0, err}, 32'd0);
        req = 1'b0;
        tick();
        check("int_ready_pulse", {31'd0, ready}, 32'd0);
        check("int_no_ext_req", {31'd0, saw_ext_req}, 32'd0);

        // external fetch, ack after 3 cycles
        adress = 32'h2000; cs = 1'b1; req = 1'b1;
        tick();
        tick();
        check("ext_req_high", {31'd0, ext_req}, 32'd1);
        check("ext_addr", ext_addr, 32'h2000);
        tick();
        tick();
        check("ext_req_still", {31'd0, ext_req}, 32'd1);
        ext_ack = 1'b1; ext_data = 32'hDEAD_BEEF;
        tick();
        check("ext_req_drop", {31'd0, ext_req}, 32'd0);
        check("ext_no_ready_ack_hi", {31'd0, ready}, 32'd0);
        ext_ack = 1'b0;
        tick();
        check("ext_ready", {31'd0, ready}, 32'd1);
        check("ext_rdata", rdata, 32'hDEAD_BEEF);
        check("ext_err", {31'd0, err}, 32'd0);
        req = 1'b0;
        tick();
        check("ext_ready_pulse", {31'd0, ready}, 32'd0);

        // timeout
        adress = 32'h1430; cs = 1'b1; req = 1'b1;
        tick();
        tick();
        n = 0;
        while (ext_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, 32'd16);
        check("to_no_ready_rel", {31'd0, ready}, 32'd0);
        tick();
        check("to_ready", {31'd0, ready}, 32'd1);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_rdata", rdata, 32'h0000_0000);
        req = 1'b0;
        tick();
        check("to_err_pulse", {31'd0, err}, 32'd0);
        check("to_ready_pulse", {31'd0, ready}, 32'd0);

        // ack held high after capture; req dropped early
        adress = 32'h3000; cs = 1'b1; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("hold_ext_req", {31'd0, ext_req}, 32'd1);
        ext_ack = 1'b1; ext_data = 32'h1234_5678;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_no_ready", {31'd0, ready}, 32'd0);
            tick();
        end
        ext_ack = 1'b0;
        check("hold_no_ready_last", {31'd0, ready}, 32'd0);
        tick();
        check("hold_ready", {31'd0, ready}, 32'd1);
        check("hold_rdata", rdata, 32'h1234_5678);
        tick();

        // ack coincident with the timeout edge
        adress = 32'h4000; cs = 1'b1; req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("race_ext_req", {31'd0, ext_req}, 32'd1);
        ext_ack = 1'b1; ext_data = 32'hCAFE_F00D;
        tick();
        ext_ack = 1'b0;
        tick();
        check("race_ready", {31'd0, ready}, 32'd1);
        check("race_rdata", rdata, 32'hCAFE_F00D);
        check("race_err", {31'd0, err}, 32'd0);
        req = 1'b0;
        tick();

        // asynchronous reset mid external request
        adress = 32'h5000; cs = 1'b1; req = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pre_ext_req", {31'd0, ext_req}, 32'd1);
        #2 Rst = 1'b0;
        #1;
        check("rst_ext_req", {31'd0, ext_req}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ext_addr", ext_addr, 32'd0);
        req = 1'b0; cs = 1'b0;
        #10 Rst = 1'b1;
        tick();
        tick();
        check("rst_idle_ext_req", {31'd0, ext_req}, 32'd0);
        adress = 32'h142F; int_data = 32'h0BAD_F00D; req = 1'b1; saw_ext_req = 1'b0;
        tick();
        tick();
        tick();
        check("rst_int_ready", {31'd0, ready}, 32'd1);
        check("rst_int_rdata", rdata, 32'h0BAD_F00D);
        check("rst_int_addr", ext_addr, 32'h142F);
        check("rst_int_no_ext", {31'd0, saw_ext_req}, 32'd0);
        req = 1'b0;
        tick();

        // back-to-back fetches with req held high
        adress = 32'h6000; cs = 1'b0; int_data = 32'h1111_1111; req = 1'b1;
        idx1 = 0; idx2 = 0; rd1 = '0; rd2 = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ready === 1'b1) begin
                if (idx1 == 0) begin
                    idx1 = i; rd1 = rdata;
                    adress = 32'h6004; int_data = 32'h2222_2222;
                end else if (idx2 == 0) begin
                    idx2 = i; rd2 = rdata;
                end
            end
        end
        req = 1'b0;
        check("b2b_first_at", idx1, 32'd3);
        check("b2b_second_at", idx2, 32'd7);
        check("b2b_rdata1", rd1, 32'h1111_1111);
        check("b2b_rdata2", rd2, 32'h2222_2222);
        check("b2b_addr2", ext_addr, 32'h6004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_prog_bridge.md
EXT_PROG_BRIDGE -- requirements
Module: ext_prog_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum number of cycles to wait for ext_ack before aborting a fetch.
REQ-002 Parameter: ERR_WORD, default 32'h0000_0000, value returned on rdata when a fetch times out.
REQ-003 Port: Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: Rst  input  1  reset; asynchronous and active-low.
REQ-005 Port: adress  input  32  CPU fetch address; held stable from req until ready.
REQ-006 Port: req  input  1  CPU fetch request; level, held high until ready.
REQ-007 Port: cs  input  1  from the program address decoder, registered one cycle behind adress; 0 = internal memory, 1 = external memory.
REQ-008 Port: int_data  input  32  internal program memory read word; valid one cycle after address.
REQ-009 Port: ext_addr  output  32  external bus address.
REQ-010 Port: ext_req  output  1  external bus request; 4-phase handshake.
REQ-011 Port: ext_ack  input  1  external bus acknowledge.
REQ-012 Port: ext_data  input  32  external read word; valid while ext_ack=1.
REQ-013 Port: rdata  output  32  fetched instruction word, registered.
REQ-014 Port: ready  output  1  one-cycle pulse: rdata valid, fetch complete.
REQ-015 Port: err  output  1  one-cycle pulse coincident with ready when the fetch timed out.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, INT_RD, EXT_REQ, EXT_REL, DONE.
REQ-017 IDLE: req=1 -> DECODE; adress latched into ext_addr.
REQ-018 DECODE: exactly one cycle, allowing registered cs to settle; next edge samples cs: 0 -> INT_RD, 1 -> EXT_REQ.
REQ-019 INT_RD: on next edge, rdata <= int_data; -> DONE.
REQ-020 EXT_REQ: ext_req=1, ext_addr stable; wait counter increments each cycle from 0.
REQ-021 EXT_REQ with ext_ack=1: rdata <= ext_data, ext_req deasserted next cycle; -> EXT_REL.
REQ-022 EXT_REQ with counter = TIMEOUT-1 and ext_ack=0: rdata <= ERR_WORD, err flag set; -> EXT_REL.
REQ-023 EXT_REL: ext_req=0; stay until ext_ack=0, then -> DONE (ack already low on timeout -> DONE next cycle).
REQ-024 DONE: ready=1 (and err=1 if flagged) for exactly one cycle; -> IDLE; counter and err flag cleared.
REQ-025 If ack and timeout occur on the same edge, ack SHALL win (data captured, no err).
REQ-026 Internal fetch latency: ready high in the 4th cycle after req first sampled (IDLE, DECODE, INT_RD, DONE).
REQ-027 req deasserted before ready SHALL be ignored; the fetch completes normally.
REQ-028 A new req SHALL only be accepted in IDLE; req still high in the cycle after DONE starts a new fetch.
REQ-029 ext_req SHALL never rise while ext_ack=1 (EXT_REQ is entered only via DECODE after EXT_REL completes).
REQ-030 Counter width SHALL be clog2(TIMEOUT)+1 bits; it does not wrap.

Reset
REQ-031 Rst=0 SHALL immediately force state=IDLE, ext_req=0, ready=0, err=0, rdata=0, ext_addr=0, counter=0, without waiting for Clk.
REQ-032 Reset during EXT_REQ SHALL drop ext_req at once; after release, the FSM waits in IDLE for a fresh req.

Verification
REQ-033 adress=0x1030, cs=0, int_data=0x2002_0005 -> ready for one cycle, 3 cycles after req sampled, with rdata=0x2002_0005, err=0, ext_req never high.
REQ-034 adress=0x2000, cs=1, ext_ack 3 cycles after ext_req, ext_data=0xDEADBEEF -> ext_addr=0x2000, rdata=0xDEADBEEF, ready pulse after ack falls, err=0.
REQ-035 adress=0x1430, cs=1, ext_ack never -> ext_req high 16 cycles then low, ready=1 and err=1 together, rdata=0x0000_0000.
REQ-036 ext_ack held high 5 cycles after capture -> FSM holds in EXT_REL and ready fires only after ext_ack falls.
REQ-037 Rst pulsed low mid EXT_REQ -> ext_req=0 and all outputs 0 asynchronously; next fetch at 0x142F with cs=0 completes as internal.
REQ-038 Back-to-back req held high over two fetches -> two distinct ready pulses, separated by at least the IDLE and DECODE cycles.
